// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits, even parity, one stop bit, oversampled by the system clock.
// Good bytes appear on parallel_out with a one-cycle data_valid strobe; bad frames are dropped silently.
module uart_rx_core #(
    parameter int BASE_FREQ = 50000000,
    parameter int BAUDRATE  = 921600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] parallel_out,
    output logic       data_valid
);

    localparam int CLKS_PER_BIT = BASE_FREQ / BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           active_state, state_d;
    logic [1:0]       sync_q;
    logic             rx;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             parity_ok_q, parity_ok_d;
    logic             valid_q, valid_d;

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    assign rx = sync_q[1];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d     = active_state;
        clk_cnt_d   = clk_cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        parity_ok_d = parity_ok_q;
        valid_d     = 1'b0;

        case (active_state)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx) state_d = START;
            end
            START: begin
                if (clk_cnt_q == HALF_END) begin
                    clk_cnt_d = '0;
                    state_d   = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx;
                    if (bit_idx_q == 3'd7) state_d = PARITY;
                    else                   bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            PARITY: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d   = '0;
                    parity_ok_d = (rx == ^shift_q);
                    state_d     = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    if (rx && parity_ok_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                    // Returning at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_state <= IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            parity_ok_q  <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            active_state <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            parity_ok_q  <= parity_ok_d;
            valid_q      <= valid_d;
        end
    end

    assign parallel_out = data_q;
    assign data_valid   = valid_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: a serial frame driver feeds a byte scoreboard,
// and a negedge monitor pops and compares on every data_valid strobe.
module tb_uart_rx_core;

    localparam int CPB = 54;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] parallel_out;
    logic       data_valid;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_valid = 1'b0;

    uart_rx_core #(
        .BASE_FREQ(50000000),
        .BAUDRATE (921600)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .parallel_out(parallel_out),
        .data_valid  (data_valid)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: every strobe must be single-cycle and match the oldest expected byte.
    always @(negedge clk) begin
        if (data_valid) begin
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            check("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("rx_byte", {24'd0, parallel_out}, {24'd0, exp_q.pop_front()});
        end
        prev_valid = data_valid;
    end

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    // Drives one frame; abort_bit >= 0 stops half-way through that bit position.
    task automatic send_frame(input logic [7:0] data, input logic par_flip,
                              input logic stop_bit, input int abort_bit);
        logic [10:0] bits;
        bits = {stop_bit, (^data) ^ par_flip, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            serial_in = bits[i];
            if (i == abort_bit) begin
                repeat (CPB / 2) @(negedge clk);
                return;
            end
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_good(input logic [7:0] data);
        exp_q.push_back(data);
        last_good = data;
        send_frame(data, 1'b0, 1'b1, -1);
    endtask

    task automatic gap_check(input string tag);
        serial_in = 1'b1;
        idle_bits(5);
        check({tag, "_pending"}, exp_q.size(), 32'd0);
        check({tag, "_hold"}, {24'd0, parallel_out}, {24'd0, last_good});
    endtask

    initial begin
        rst       = 1'b0;
        serial_in = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_out", {24'd0, parallel_out}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_state", {29'd0, dut.active_state}, 32'd0);
        rst = 1'b1;
        idle_bits(2);

        send_good(8'h55); gap_check("good55");
        send_good(8'hAA); gap_check("goodAA");
        send_good(8'h3C); gap_check("good3C");

        send_frame(8'h3C, 1'b1, 1'b1, -1);
        gap_check("parity_err");
        check("parity_err_state", {29'd0, dut.active_state}, 32'd0);

        send_frame(8'hA5, 1'b0, 1'b0, -1);
        gap_check("frame_err");
        send_good(8'h0F); gap_check("good0F");

        serial_in = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_start", {29'd0, dut.active_state}, 32'd1);
        serial_in = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_idle", {29'd0, dut.active_state}, 32'd0);
        gap_check("glitch");
        send_good(8'hFF); gap_check("goodFF");

        send_good(8'h01);
        send_good(8'h80);
        gap_check("b2b");

        send_frame(8'h5A, 1'b0, 1'b1, 5);
        #3 rst = 1'b0;
        #1;
        check("midrst_out", {24'd0, parallel_out}, 32'd0);
        check("midrst_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_state", {29'd0, dut.active_state}, 32'd0);
        last_good = 8'h00;
        serial_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        gap_check("midrst");
        send_good(8'hC3); gap_check("goodC3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial-to-parallel UART receiver for 8-data-bit frames with an even-parity bit and one stop bit. Oversamples the asynchronous serial line with the system clock, validates start, parity and stop bits, and presents each good byte on a parallel bus with a one-cycle valid strobe. It is the receive half of the project UART and sits between the board RX pin and the byte-consuming logic.

## Interface
- `BASE_FREQ`, default 50000000: system clock frequency in Hz.
- `BAUDRATE`, default 921600: serial bit rate in bit/s.
- Derived constant: CLKS_PER_BIT = BASE_FREQ / BAUDRATE (integer division; 54 at the defaults). HALF_BIT = CLKS_PER_BIT / 2 (27).
- `clk`  input  1  system clock, all logic on its rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `serial_in`  input  1  asynchronous serial line, idles high.
- `parallel_out`  output  8  last correctly received byte.
- `data_valid`  output  1  one-cycle strobe: `parallel_out` has just been updated.

## Operation
- Frame: start bit (0), data bits d0..d7 LSB first, parity bit = XOR of d0..d7 (even parity), stop bit (1).
- `serial_in` passes through a 2-flop synchronizer; all decisions use the synchronized value.
- State register named `active_state` (3 bits): IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- IDLE: bit counter and clock counter cleared. Synchronized line low -> START.
- START: count HALF_BIT-1 clocks, then sample. Line still low -> clear clock counter, go to DATA. Line high (glitch) -> back to IDLE, no output.
- DATA: every CLKS_PER_BIT clocks (mid-bit), sample into shift register position bit_index (0..7). After bit 7 -> PARITY.
- PARITY: after CLKS_PER_BIT clocks, sample; compare with XOR of the 8 shifted bits; record the match flag -> STOP.
- STOP: after CLKS_PER_BIT clocks, sample. Stop = 1 and parity matched -> load `parallel_out` with the shift register and pulse `data_valid`. Otherwise, on parity error or framing error, discard the byte with no pulse and leave `parallel_out` unchanged. Either way -> IDLE.
- After STOP the FSM is back in IDLE at mid-stop-bit. A new start bit detected from there is accepted, which allows back-to-back frames.
- `parallel_out` holds its value between frames. It changes only on a good frame.

## Timing
- Reset (`rst`=0, async): `active_state`=IDLE, `parallel_out`=8'h00, `data_valid`=0, counters, shift register and synchronizer cleared to idle (synchronizer flops reset to 1).
- Reset asserted mid-frame: the frame is aborted immediately, nothing is output, and reception restarts at the next low seen in IDLE.
- Sample points: start at about HALF_BIT, each later bit at about HALF_BIT + n·CLKS_PER_BIT clocks after the synchronized falling edge, plus the 2-cycle synchronizer delay.
- `data_valid` rises about 2 + HALF_BIT + 10·CLKS_PER_BIT clocks after the line falling edge, roughly mid-stop-bit. It is high for exactly 1 clock, and `parallel_out` is valid in that same cycle.
- `data_valid` is never high for two consecutive cycles. It is 0 in every cycle except the update cycle.
- Tolerance: must receive correctly with a sender bit period of CLKS_PER_BIT clocks ±2%.

## Test plan
- Reset: hold `rst`=0 for 5 clocks, release -> `parallel_out`=8'h00, `data_valid`=0, `active_state`=0.
- Good frames at 921600 baud, 54 clocks/bit, with about 5 idle bit times between frames:
  - 8'h55, parity 0 -> one `data_valid` pulse and `parallel_out`=8'h55.
  - Then 8'hAA, parity 0 -> 8'hAA.
  - Then 8'h3C, parity 0 -> 8'h3C.
  - Check that each value is still held at the end of the idle gap.
- Parity error: send 8'h3C with parity bit 1 -> no `data_valid`, `parallel_out` keeps the previous value, FSM back in IDLE.
- Framing error: send 8'hA5 with stop bit 0 -> no pulse and no output change. The next good frame, 8'h0F, is then received correctly.
- Glitch: drive `serial_in` low for 10 clocks (less than HALF_BIT), then high -> FSM returns START->IDLE, no pulse. A following 8'hFF frame is received correctly.
- Back-to-back / reset mid-frame:
  - Two frames 8'h01, 8'h80 with no idle gap -> two pulses with the correct bytes.
  - Assert `rst` during data bit 4 -> immediate IDLE, `parallel_out`=8'h00, no pulse.
